// File: rtl/shift_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_engine_pkg
// Description : Shared definitions for the shift engine: operation encodings,
//               FSM state encodings and a width helper for the per-cycle
//               shift amount.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_engine_pkg;

    // Operation encodings as presented on in_op
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    // Engine FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Bits needed to hold a per-cycle shift amount in the range 0..step
    function automatic int step_amount_w(input int step);
        return $clog2(step) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_engine_if
// Description : Request/response bundle for the shift engine.
//               Request : in_valid, in_ready, in_op, in_value, in_shamt
//               Response: out_valid, out_ready, out_value, out_zero
//               master = requester/consumer side, slave = engine side.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_engine_if #(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_op;
    logic [WIDTH-1:0]   in_value;
    logic [SHAMT_W-1:0] in_shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_value;
    logic               out_zero;

    modport master (
        output in_valid, in_op, in_value, in_shamt, out_ready,
        input  in_ready, out_valid, out_value, out_zero
    );

    modport slave (
        input  in_valid, in_op, in_value, in_shamt, out_ready,
        output in_ready, out_valid, out_value, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/shift_engine_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational single-step shifter. Shifts a WIDTH-bit value
//               by i_k bits (i_k <= STEP) according to i_op.
//               Ports: i_op (operation), i_value (operand), i_k (amount),
//                      o_value (shifted result).
//               Macro SHIFT_ENGINE_ROR_EN enables rotate right; without it
//               OP_ROR falls through to a logical right shift.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_engine_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K_W   = 1
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_value,
    input  logic [K_W-1:0]   i_k,
    output logic [WIDTH-1:0] o_value
);

    always_comb begin
        o_value = i_value >> i_k;
        case (i_op)
            OP_SLL:  o_value = i_value << i_k;
            OP_SRA:  o_value = $unsigned($signed(i_value) >>> i_k);
`ifdef SHIFT_ENGINE_ROR_EN
            // A shift by WIDTH yields zero, so i_k == 0 returns the operand.
            OP_ROR:  o_value = (i_value >> i_k) | (i_value << (WIDTH - 32'(i_k)));
`endif
            default: o_value = i_value >> i_k;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : shift_engine
// Description : Multi-cycle variable shifter (SLL/SRL/SRA/ROR) applying up to
//               STEP bits of shift per cycle behind valid/ready handshakes.
//               Ports: clk, rst_n (async active-low), bus (shift_engine_if
//               slave modport carrying request and response).
//               Macro SHIFT_ENGINE_ROR_EN enables rotate right (see
//               shift_step); otherwise op 11 behaves as SRL.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_engine
    import shift_engine_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_engine_if.slave  bus
);

    localparam int c_shamt_w = $clog2(WIDTH);
    localparam int c_k_w     = step_amount_w(STEP);
    // STEP may equal WIDTH, which needs one bit more than a shift amount
    localparam logic [c_shamt_w:0] c_step = (c_shamt_w + 1)'(STEP);

    state_e                 r_state;
    op_e                    r_op;
    logic [WIDTH-1:0]       r_value;
    logic [c_shamt_w-1:0]   r_rem;
    logic                   r_in_ready;
    logic                   r_out_valid;

    logic [c_k_w-1:0]       w_k;
    logic [c_shamt_w-1:0]   w_rem_next;
    logic [WIDTH-1:0]       w_step_value;

    // k = min(STEP, remaining)
    always_comb begin
        if ({1'b0, r_rem} >= c_step) begin
            w_k = c_k_w'(STEP);
        end else begin
            w_k = c_k_w'(r_rem);
        end
    end

    // k never exceeds remaining, so this cannot underflow
    assign w_rem_next = r_rem - c_shamt_w'(w_k);

    shift_step #(
        .WIDTH (WIDTH),
        .K_W   (c_k_w)
    ) u_step (
        .i_op    (r_op),
        .i_value (r_value),
        .i_k     (w_k),
        .o_value (w_step_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_SLL;
            r_value     <= '0;
            r_rem       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_op       <= op_e'(bus.in_op);
                        r_value    <= bus.in_value;
                        r_rem      <= bus.in_shamt;
                        r_in_ready <= 1'b0;
                        if (bus.in_shamt == '0) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_value <= w_step_value;
                    r_rem   <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_value = r_value;
    assign bus.out_zero  = (r_value == '0);

endmodule
`default_nettype wire

// File: tb/tb_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_engine
// Description : Self-checking bench for shift_engine. Runs a STEP=1 and a
//               STEP=4 instance side by side on identical requests and checks
//               results, Out_Zero, latency and handshake behaviour against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_engine;
    import shift_engine_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shift_engine_if #(.WIDTH(32)) bus1 ();
    shift_engine_if #(.WIDTH(32)) bus4 ();

    shift_engine #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    shift_engine #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, req);
        end
    endtask

    // Reference: each op expressed as plain shifts and masks on the whole word
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] v, input int sh);
        logic [31:0] ones = 32'hFFFF_FFFF;
        logic [31:0] srl  = v >> sh;
        case (op)
            2'b00:   return v << sh;
            2'b01:   return srl;
            2'b10:   return v[31] ? (srl | ~(ones >> sh)) : srl;
`ifdef SHIFT_ENGINE_ROR_EN
            default: return (sh == 0) ? v : (srl | (v << (32 - sh)));
`else
            default: return srl;
`endif
        endcase
    endfunction

    task automatic drive(input logic vld, input logic [1:0] op, input logic [31:0] val, input int sh);
        bus1.in_valid = vld;  bus4.in_valid = vld;
        bus1.in_op    = op;   bus4.in_op    = op;
        bus1.in_value = val;  bus4.in_value = val;
        bus1.in_shamt = 5'(sh);
        bus4.in_shamt = 5'(sh);
    endtask

    task automatic set_ready(input logic r);
        bus1.out_ready = r;
        bus4.out_ready = r;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/s1 in_ready"},  32'(bus1.in_ready),  32'd1);
        check({tag, "/s1 out_valid"}, 32'(bus1.out_valid), 32'd0);
        check({tag, "/s1 out_value"}, bus1.out_value,      32'd0);
        check({tag, "/s1 out_zero"},  32'(bus1.out_zero),  32'd1);
        check({tag, "/s4 in_ready"},  32'(bus4.in_ready),  32'd1);
        check({tag, "/s4 out_valid"}, 32'(bus4.out_valid), 32'd0);
        check({tag, "/s4 out_value"}, bus4.out_value,      32'd0);
        check({tag, "/s4 out_zero"},  32'(bus4.out_zero),  32'd1);
    endtask

    // One request with Out_Ready held high; observes both instances until each
    // has completed its handshake and returned to idle.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] val, input int sh);
        logic [31:0] want = ref_shift(op, val, sh);
        int          steps[2] = '{1, 4};
        int          got_lat[2];
        logic [31:0] got_val[2];
        logic        got_zero[2];
        logic        got_rdy[2];
        bit          seen[2];
        bit          rdy_done[2];
        logic        vld[2];
        logic        rdy[2];
        logic [31:0] vs[2];
        logic        zs[2];
        for (int d = 0; d < 2; d++) begin
            got_lat[d] = -1; got_val[d] = 'x; got_zero[d] = 1'bx; got_rdy[d] = 1'b0;
            seen[d] = 1'b0; rdy_done[d] = 1'b0;
        end
        @(negedge clk);
        set_ready(1'b1);
        drive(1'b1, op, val, sh);
        @(posedge clk);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            vld[0] = bus1.out_valid; rdy[0] = bus1.in_ready; vs[0] = bus1.out_value; zs[0] = bus1.out_zero;
            vld[1] = bus4.out_valid; rdy[1] = bus4.in_ready; vs[1] = bus4.out_value; zs[1] = bus4.out_zero;
            if (c == 0) drive(1'b0, 2'b00, 32'd0, 0);
            for (int d = 0; d < 2; d++) begin
                if (!seen[d] && vld[d]) begin
                    seen[d] = 1'b1; got_lat[d] = c; got_val[d] = vs[d]; got_zero[d] = zs[d];
                end else if (seen[d] && !rdy_done[d] && c == got_lat[d] + 1) begin
                    got_rdy[d] = rdy[d] && !vld[d];
                    rdy_done[d] = 1'b1;
                end
            end
            if (rdy_done[0] && rdy_done[1]) break;
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s/s%0d latency", tag, steps[d]), 32'(got_lat[d]),
                  32'((sh + steps[d] - 1) / steps[d]));
            check($sformatf("%s/s%0d value", tag, steps[d]), got_val[d], want);
            check($sformatf("%s/s%0d zero", tag, steps[d]), 32'(got_zero[d]), 32'(want == 32'd0));
            check($sformatf("%s/s%0d ready_after", tag, steps[d]), 32'(got_rdy[d]), 32'd1);
        end
    endtask

    initial begin
        // Global time bound so the run always terminates
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] rval;
        int          rsh;

        // Reset with a request offered: must not be taken
        rst_n = 1'b0;
        set_ready(1'b0);
        drive(1'b1, OP_SLL, 32'h1, 5);
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        drive(1'b0, OP_SLL, 32'h0, 0);
        @(negedge clk);
        check("no_accept_in_reset/s1", 32'(bus1.in_ready), 32'd1);
        check("no_accept_in_reset/s4", 32'(bus4.in_ready), 32'd1);

        // Directed cases
        do_op("sll_1_by_4",      OP_SLL, 32'h0000_0001, 4);
        do_op("sra_msb_by_31",   OP_SRA, 32'h8000_0000, 31);
        do_op("ror_1_by_1",      OP_ROR, 32'h0000_0001, 1);
        do_op("ror_by_0",        OP_ROR, 32'hA5A5_0F0F, 0);
        do_op("sra_pos_by_7",    OP_SRA, 32'h7F00_0000, 7);
        do_op("srl_by_31",       OP_SRL, 32'hFFFF_FFFF, 31);

        // SRL by 0 with back-pressure: result must hold, no new request taken
        @(negedge clk);
        set_ready(1'b0);
        drive(1'b1, OP_SRL, 32'h0000_0003, 0);
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) drive(1'b1, OP_SLL, 32'hFFFF_FFFF, 3);
            check($sformatf("bp%0d/s1 valid", i), 32'(bus1.out_valid), 32'd1);
            check($sformatf("bp%0d/s1 value", i), bus1.out_value, 32'h3);
            check($sformatf("bp%0d/s1 in_ready", i), 32'(bus1.in_ready), 32'd0);
            check($sformatf("bp%0d/s4 valid", i), 32'(bus4.out_valid), 32'd1);
            check($sformatf("bp%0d/s4 value", i), bus4.out_value, 32'h3);
        end
        check("bp/s1 zero", 32'(bus1.out_zero), 32'd0);
        drive(1'b0, OP_SLL, 32'h0, 0);
        set_ready(1'b1);
        @(negedge clk);
        check("bp_release/s1 valid", 32'(bus1.out_valid), 32'd0);
        check("bp_release/s1 in_ready", 32'(bus1.in_ready), 32'd1);
        check("bp_release/s4 in_ready", 32'(bus4.in_ready), 32'd1);

        // Reset asserted mid-shift (second SHIFT cycle of SLL by 8)
        @(negedge clk);
        drive(1'b1, OP_SLL, 32'h0000_0001, 8);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, OP_SLL, 32'h0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst_sll", OP_SLL, 32'h0000_0001, 1);

        // Random requests
        for (int n = 0; n < 24; n++) begin
            rop  = 2'($urandom_range(0, 3));
            rval = $urandom;
            if (n % 4 == 0) rval = rval | 32'h8000_0000;
            rsh  = $urandom_range(0, 31);
            do_op($sformatf("rand%0d", n), rop, rval, rsh);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
